// File: rtl/uart_rx_ctrl_pkg.sv
// rtl/uart_rx_ctrl_pkg.sv - shared types, defaults and helpers for the UART receive controller
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_t;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_BAUD_DIV   = 27;

    // Width needed to count 0..word_length data bits
    function automatic int bit_cnt_width(input int word_length);
        return $clog2(word_length + 1);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - link between the RX bit-timing controller and the RX shift register
interface uart_rx_ctrl_if;
    logic serial_bit;
    logic shift;
    logic parity;
    logic parity_int;
    logic rx_done;
    logic parity_error;
    logic framing_error;
    logic busy;

    modport master (
        output serial_bit, shift, rx_done, parity_error, framing_error, busy,
        input  parity, parity_int
    );

    modport slave (
        input  serial_bit, shift, rx_done, parity_error, framing_error, busy,
        output parity, parity_int
    );
endinterface

// File: rtl/uart_rx_ctrl_baud_tick.sv
// rtl/uart_rx_ctrl_baud_tick.sv - oversample tick divider with enable and restart
module uart_baud_tick #(
    parameter int BAUD_DIV  = 27,
    parameter int DIV_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(BAUD_DIV - 1);

    logic [DIV_WIDTH-1:0] cnt;

    // Free-run 0..BAUD_DIV-1 while enabled; parked at zero when disabled or restarted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!en || restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && !restart && (cnt == LAST);
endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX bit-timing controller; optional RX_MAJORITY_EN enables 2-of-3 sampling
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int WORD_LENGTH = 8,
    parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
    parameter int BAUD_DIV    = DEFAULT_BAUD_DIV,
    parameter int DIV_WIDTH   = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = bit_cnt_width(WORD_LENGTH);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_LENGTH - 1);

    rx_state_t        state;
    logic [CNT_W-1:0] tick_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             rx_meta;
    logic             rx_s;
    logic             tick;
    logic             start_det;
    logic             sample;
    logic             serial_bit_r;
    logic             shift_r;
    logic             rx_done_r;
    logic             parity_error_r;
    logic             framing_error_r;
    logic             busy_r;

    // Two-flop synchroniser; idle-high line so both flops reset to 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // A new frame may begin from IDLE or straight out of DONE
    assign start_det = !rx_s && (state == IDLE || state == DONE);

    uart_baud_tick #(
        .BAUD_DIV  (BAUD_DIV),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_tick (
        .clk     (clk),
        .reset   (reset),
        .en      (state != IDLE),
        .restart (start_det),
        .tick    (tick)
    );

`ifdef RX_MAJORITY_EN
    logic [1:0] hist;

    // Keep rx_s from the two previous ticks for the majority vote
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= 2'b11;
        end else if (tick) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign sample = rx_s;
`endif

    // Frame sequencer; all outputs registered, shift and rx_done are single-clk strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            tick_cnt        <= '0;
            bit_cnt         <= '0;
            serial_bit_r    <= 1'b0;
            shift_r         <= 1'b0;
            rx_done_r       <= 1'b0;
            parity_error_r  <= 1'b0;
            framing_error_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            shift_r   <= 1'b0;
            rx_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!rx_s) begin
                        state           <= START;
                        busy_r          <= 1'b1;
                        parity_error_r  <= 1'b0;
                        framing_error_r <= 1'b0;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            if (!sample) begin
                                state <= DATA;
                            end else begin
                                state  <= IDLE;
                                busy_r <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt     <= '0;
                            shift_r      <= 1'b1;
                            serial_bit_r <= sample;
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                state   <= PARITY;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt     <= '0;
                            shift_r      <= 1'b1;
                            serial_bit_r <= sample;
                            state        <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt        <= '0;
                            framing_error_r <= ~sample;
                            state           <= DONE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    rx_done_r      <= 1'b1;
                    parity_error_r <= bus.parity ^ bus.parity_int;
                    tick_cnt       <= '0;
                    bit_cnt        <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.serial_bit    = serial_bit_r;
    assign bus.shift         = shift_r;
    assign bus.rx_done       = rx_done_r;
    assign bus.parity_error  = parity_error_r;
    assign bus.framing_error = framing_error_r;
    assign bus.busy          = busy_r;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx = 1'b1;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl #(
        .WORD_LENGTH (8),
        .OVERSAMPLE  (16),
        .BAUD_DIV    (1),
        .DIV_WIDTH   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Shift-register stand-in: shifts right, new bit at the top; parity is even over data
    logic [8:0] sr;
    always @(posedge clk or negedge reset) begin
        if (!reset) sr <= '0;
        else if (bus.shift) sr <= {bus.serial_bit, sr[8:1]};
    end
    assign bus.parity     = sr[8];
    assign bus.parity_int = ^sr[7:0];

    int         cyc = 0;
    int         shift_cnt = 0;
    int         done_cnt = 0;
    int         gap_bad = 0;
    int         last_shift = 0;
    logic [8:0] cap = '0;
    logic       pe_done = 1'b0;
    logic       fe_done = 1'b0;
    logic       any_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe strobes away from the active edge
    always @(negedge clk) begin
        if (bus.shift) begin
            if ((shift_cnt % 9) != 0 && (cyc - last_shift) != 16) gap_bad = gap_bad + 1;
            cap[shift_cnt % 9] = bus.serial_bit;
            last_shift = cyc;
            shift_cnt = shift_cnt + 1;
        end
        if (bus.rx_done) begin
            done_cnt = done_cnt + 1;
            pe_done = bus.parity_error;
            fe_done = bus.framing_error;
            any_err = any_err | bus.parity_error | bus.framing_error;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        shift_cnt = 0;
        done_cnt = 0;
        gap_bad = 0;
        cap = '0;
        pe_done = 1'b0;
        fe_done = 1'b0;
        any_err = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check(tag, {31'b0, bus.busy}, 32'd0);
    endtask

    function automatic logic [5:0] outs();
        return {bus.shift, bus.serial_bit, bus.rx_done, bus.parity_error, bus.framing_error, bus.busy};
    endfunction

    initial begin
        reset = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {26'b0, outs()}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 0xA5, good parity, good stop
        clear_stats();
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_idle("a5_idle");
        check("a5_shifts", shift_cnt, 32'd9);
        check("a5_bits", {23'b0, cap}, {23'b0, 1'b0, 8'hA5});
        check("a5_gaps", gap_bad, 32'd0);
        check("a5_done", done_cnt, 32'd1);
        check("a5_errors", {30'b0, pe_done, fe_done}, 32'd0);
        check("a5_sr_data", {24'b0, sr[7:0]}, 32'hA5);

        // 0xA5 with wrong parity bit
        clear_stats();
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_idle("a5p_idle");
        check("a5p_done", done_cnt, 32'd1);
        check("a5p_parity_error", {31'b0, pe_done}, 32'd1);
        check("a5p_framing_error", {31'b0, fe_done}, 32'd0);
        check("a5p_sticky", {31'b0, bus.parity_error}, 32'd1);

        // Short low glitch: start detect clears errors, then false start
        clear_stats();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        check("glitch_pe_cleared", {31'b0, bus.parity_error}, 32'd0);
        check("glitch_busy", {31'b0, bus.busy}, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("glitch_not_busy", {31'b0, bus.busy}, 32'd0);
        check("glitch_shifts", shift_cnt, 32'd0);
        check("glitch_done", done_cnt, 32'd0);

        // 0x3C with a bad stop bit
        clear_stats();
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        wait_idle("fe_idle");
        check("fe_shifts", shift_cnt, 32'd9);
        check("fe_bits", {23'b0, cap}, {23'b0, 1'b0, 8'h3C});
        check("fe_done", done_cnt, 32'd1);
        check("fe_framing_error", {31'b0, fe_done}, 32'd1);
        check("fe_parity_error", {31'b0, pe_done}, 32'd0);

        // Reset after the third data shift, then a clean 0x5A
        clear_stats();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("mid_shifts_before_reset", shift_cnt, 32'd3);
        reset = 1'b0;
        #1;
        check("mid_reset_outputs", {26'b0, outs()}, 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check("mid_reset_no_done", done_cnt, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        clear_stats();
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_idle("r5a_idle");
        check("r5a_shifts", shift_cnt, 32'd9);
        check("r5a_sr_data", {24'b0, sr[7:0]}, 32'h5A);
        check("r5a_done", done_cnt, 32'd1);
        check("r5a_errors", {30'b0, pe_done, fe_done}, 32'd0);

        // Back-to-back 0xFF then 0x00
        clear_stats();
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b1);
        wait_idle("b2b_idle");
        check("b2b_shifts", shift_cnt, 32'd18);
        check("b2b_done", done_cnt, 32'd2);
        check("b2b_gaps", gap_bad, 32'd0);
        check("b2b_errors", {31'b0, any_err}, 32'd0);
        check("b2b_sr_data", {24'b0, sr[7:0]}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
